// File: rtl/adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipe
// Purpose  : Segmented, pipelined adder/subtractor with valid/ready flow control
// Revision : 1.0 - initial release
// ============================================================================
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_carry,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic [TAG_W-1:0] o_tag
);

  localparam int SEG = WIDTH / STAGES;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] load;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             cy_q  [STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];
  logic             ovf_q;
  logic             zero_q;

  // A stage may load when it is empty or when some slot downstream of it
  // (or the consumer) frees up this cycle; scanning from the output end
  // avoids a combinational chain through the load vector itself.
  always_comb begin
    logic hole;
    load = '0;
    hole = i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = ~vld[k] | hole;
      hole    = hole | ~vld[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      vld <= '0;
    end else begin
      vld <= (load & vin) | (~load & vld);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic [TAG_W-1:0] t_in;
    logic [SEG:0]     seg;
    logic [WIDTH-1:0] s_next;

    if (k == 0) begin : g_first
      assign a_in   = i_a;
      assign b_in   = i_b ^ {WIDTH{i_sub}};
      assign c_in   = i_sub | i_carry;
      assign s_in   = '0;
      assign t_in   = i_tag;
      assign vin[k] = i_valid;
    end else begin : g_next
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign c_in   = cy_q[k-1];
      assign s_in   = sum_q[k-1];
      assign t_in   = tag_q[k-1];
      assign vin[k] = vld[k-1];
    end

    assign seg = {1'b0, a_in[k*SEG +: SEG]} + {1'b0, b_in[k*SEG +: SEG]}
               + {{SEG{1'b0}}, c_in};

    always_comb begin
      s_next                = s_in;
      s_next[k*SEG +: SEG]  = seg[SEG-1:0];
    end

    if (k == STAGES - 1) begin : g_last
      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          sum_q[k] <= '0;
          cy_q[k]  <= 1'b0;
          tag_q[k] <= '0;
          ovf_q    <= 1'b0;
          zero_q   <= 1'b0;
        end else if (load[k] && vin[k]) begin
          sum_q[k] <= s_next;
          cy_q[k]  <= seg[SEG];
          tag_q[k] <= t_in;
          // carry into the MSB is recovered as a ^ b ^ sum at that bit
          ovf_q    <= a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ s_next[WIDTH-1] ^ seg[SEG];
          zero_q   <= ~|s_next;
        end
      end
    end else begin : g_mid
      always_ff @(posedge i_clk) begin
        if (load[k] && vin[k]) begin
          a_q[k]   <= a_in;
          b_q[k]   <= b_in;
          sum_q[k] <= s_next;
          cy_q[k]  <= seg[SEG];
          tag_q[k] <= t_in;
        end
      end
    end
  end

  assign o_ready    = load[0];
  assign o_valid    = vld[STAGES-1];
  assign o_sum      = sum_q[STAGES-1];
  assign o_carry    = cy_q[STAGES-1];
  assign o_tag      = tag_q[STAGES-1];
  assign o_overflow = ovf_q;
  assign o_zero     = zero_q;

endmodule
`default_nettype wire

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined carry-chain adder/subtractor with valid/ready handshake; next generation of the combinational carry-select adder.
- Splits a WIDTH-bit operation into STAGES segments, one segment per register stage, so long adds meet timing in the execute/address-generation path.
- Adds subtract mode, carry-in/carry-out, signed overflow, zero flag, a sideband tag and full backpressure.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES and ≥2.
- STAGES, 4, pipeline depth in cycles and number of segments; SEG = WIDTH/STAGES bits per segment; 1 ≤ STAGES ≤ WIDTH.
- TAG_W, 4, width of the opaque tag carried alongside each operation (≥1).

Ports:
- i_clk, input, 1, clock; all state updates on rising edge.
- i_reset_n, input, 1, synchronous active-low reset.
- i_valid, input, 1, operation presented.
- o_ready, output, 1, adder can accept this cycle.
- i_a, input, WIDTH, operand A.
- i_b, input, WIDTH, operand B.
- i_sub, input, 1, 1 = A - B (B inverted, carry-in forced 1); 0 = A + B + i_carry.
- i_carry, input, 1, carry-in for add mode; ignored when i_sub = 1.
- i_tag, input, TAG_W, sideband returned with the result.
- o_valid, output, 1, result presented.
- i_ready, input, 1, downstream accepts the result.
- o_sum, output, WIDTH, result.
- o_carry, output, 1, carry out of the MSB (for subtract: 1 = no borrow).
- o_overflow, output, 1, signed two's-complement overflow.
- o_zero, output, 1, o_sum == 0.
- o_tag, output, TAG_W, tag of the presented result.

Behaviour:
- Reset (i_reset_n low at an edge):
  - All stage valid bits clear; in-flight operations are discarded with no partial result.
  - o_valid = 0 and o_ready = 1 in the cycle after reset.
  - o_sum, o_carry, o_overflow, o_zero and o_tag reset to 0.
  - Datapath registers need no reset beyond those visible outputs.
- Handshake:
  - A transfer occurs on an edge where valid && ready holds.
  - Inputs are sampled only on accepted cycles.
  - o_valid is held until i_ready; o_* remain stable while o_valid && !i_ready.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) holds a valid bit.
  - Stage k registers: carry into segment k+1, the completed low (k+1)*SEG sum bits, the remaining upper operand bits (B already conditioned), the op, and the tag.
  - The last stage's registers drive the outputs directly.
- Per-segment arithmetic:
  - Stage 0 computes segment 0 from A[SEG-1:0], B' = B ^ {WIDTH{i_sub}} and cin = i_sub | i_carry.
  - Stage k adds segment k using the registered carry from stage k-1.
  - Each segment is plain SEG-bit addition; no combinational carry crosses a register.
- Latency and throughput:
  - Latency is exactly STAGES cycles from the accept edge to o_valid high, with no stalls.
  - Throughput is 1 op/cycle.
- Flow control (bubble-collapsing):
  - Stage k loads when stage k is empty OR stage k advances.
  - The last stage advances when i_ready = 1.
  - o_ready = !v[0] | advance[0].
  - A bubble is absorbed without stalling the upstream stage.
  - With o_valid high and i_ready low, the pipeline fills to STAGES entries and then o_ready drops.
  - Ordering is strictly FIFO; no operation is dropped or duplicated.
- Flags, computed on the final full result:
  - o_carry = carry out of bit WIDTH-1.
  - o_overflow = carry into MSB XOR carry out of MSB.
  - o_zero = ~|o_sum.
- STAGES = 1: single register stage; o_ready = !o_valid | i_ready.
- Simultaneous accept and present in one edge is legal: the new op enters stage 0 while the last stage drains.
- Reset asserted mid-stall: all contents flushed; i_ready is ignored while reset is low.

Test Plan:
- WIDTH=32, STAGES=4, i_ready=1: A=0xFFFF_FFFF, B=0x0000_0001, add, cin=0 → after 4 cycles o_sum=0, o_carry=1, o_zero=1, o_overflow=0.
- Subtract: A=0x8000_0000, B=0x0000_0001, i_sub=1 → o_sum=0x7FFF_FFFF, o_carry=1, o_overflow=1.
- Subtract with borrow: A=5, B=7 → o_sum=0xFFFF_FFFE, o_carry=0, o_overflow=0.
- Back-to-back stream:
  - 16 ops on consecutive cycles with tags 0..15 and i_ready=1.
  - Results appear in order, one per cycle, from cycle 4 onward.
  - Each result matches a reference model; the cross-segment carry chain is checked with A=0x00FF_FFFF, B=1 → 0x0100_0000.
- Backpressure:
  - Hold i_ready=0 with i_valid=1 continuous.
  - Exactly 4 ops are accepted, then o_ready=0 and o_sum/o_tag stay stable.
  - After i_ready=1 for 6 cycles, the 4 buffered ops and 2 new ops drain in order.
- Reset mid-operation:
  - Assert i_reset_n=0 with 3 ops in flight and o_valid=1.
  - The next cycle shows o_valid=0 and o_ready=1.
  - A subsequent op 3+4 returns 7 with its own tag after exactly 4 cycles.
